// File: rtl/avr_cpu_fetch.sv
// avr_cpu_fetch: program counter, synchronous program-memory request and opcode register feeding execute.
// A jump costs one NOP bubble; hold freezes fetch while the memory keeps the in-flight word stable.
module avr_cpu_fetch #(
  parameter int PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic [11:0]         rjmp,
  output logic [15:0]         opcode,
  output logic                opcode_cycle,
  output logic [PC_WIDTH-1:0] op_pc,
  output logic [PC_WIDTH-1:0] pmem_addr,
  output logic                pmem_en,
  input  logic [15:0]         pmem_data
);
  logic [PC_WIDTH-1:0] pc, a1, offset, target;
  logic v1, jump;
  always_comb begin
    offset    = PC_WIDTH'($signed(rjmp));
    jump      = (rjmp != '0) && !hold;
    target    = op_pc + offset + PC_WIDTH'(1);
    pmem_en   = rst && !hold;
    pmem_addr = !rst ? RESET_VECTOR : jump ? target : pc;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc           <= RESET_VECTOR;
      a1           <= '0;
      v1           <= 1'b0;
      op_pc        <= '0;
      opcode       <= 16'h0000;
      opcode_cycle <= 1'b0;
    end else if (hold) begin
      opcode_cycle <= 1'b1;
    end else if (jump) begin
      pc           <= target + PC_WIDTH'(1);
      a1           <= target;
      v1           <= 1'b1;
      opcode       <= 16'h0000;
      opcode_cycle <= 1'b0;
    end else begin
      pc           <= pc + PC_WIDTH'(1);
      a1           <= pc;
      v1           <= 1'b1;
      opcode       <= v1 ? pmem_data : 16'h0000;
      op_pc        <= a1;
      opcode_cycle <= 1'b0;
    end
  end
endmodule

// File: tb/tb_avr_cpu_fetch.sv
// tb_avr_cpu_fetch: directed scenarios plus randomized hold/jump/reset traffic against an instruction-stream model.
module tb_avr_cpu_fetch;
  logic        clk = 0, rst = 0, hold = 0;
  logic [11:0] rjmp = '0;
  logic [15:0] opcode, pmem_data = '0;
  logic        opcode_cycle, pmem_en;
  logic [11:0] op_pc, pmem_addr;
  int errors = 0, checks = 0;

  avr_cpu_fetch dut (
    .clk(clk), .rst(rst), .hold(hold), .rjmp(rjmp),
    .opcode(opcode), .opcode_cycle(opcode_cycle), .op_pc(op_pc),
    .pmem_addr(pmem_addr), .pmem_en(pmem_en), .pmem_data(pmem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [11:0] a);
    return 16'h1000 + {4'h0, a};
  endfunction

  always @(posedge clk) if (pmem_en) pmem_data <= word(pmem_addr);

  // Model: what execute should see, derived from the addresses in flight rather than memory handshakes.
  logic [11:0] m_next = 0, m_fly = 0, m_op_pc = 0;
  logic        m_fly_v = 0, m_cyc = 0;
  logic [15:0] m_op = 0;
  always @(posedge clk) begin
    logic [11:0] t;
    t = m_op_pc + rjmp + 12'd1;
    if (!rst) begin
      m_next = 0; m_fly = 0; m_fly_v = 0; m_op_pc = 0; m_op = 0; m_cyc = 0;
    end else if (hold) begin
      m_cyc = 1;
    end else if (rjmp != 0) begin
      m_op = 0; m_cyc = 0; m_fly = t; m_fly_v = 1; m_next = t + 12'd1;
    end else begin
      m_op = m_fly_v ? word(m_fly) : 16'h0000;
      m_op_pc = m_fly; m_cyc = 0; m_fly = m_next; m_fly_v = 1; m_next = m_next + 12'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] exp_addr;
    exp_addr = !rst ? 12'd0 : (!hold && rjmp != 0) ? m_op_pc + rjmp + 12'd1 : m_next;
    chk("opcode", opcode, m_op);
    chk("op_pc", op_pc, m_op_pc);
    chk("opcode_cycle", opcode_cycle, m_cyc);
    chk("pmem_en", pmem_en, rst && !hold);
    chk("pmem_addr", pmem_addr, exp_addr);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    step(); step();
    chk("rst_en", pmem_en, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_addr", pmem_addr, 0);
    rst = 1; #1;
    chk("fill_addr0", pmem_addr, 0);
    step(); chk("fill_nop", opcode, 16'h0000);
    step(); chk("fill_w0", opcode, 16'h1000); chk("fill_pc0", op_pc, 0);
    step(); chk("fill_w1", opcode, 16'h1001); chk("fill_pc1", op_pc, 1);
    step(); chk("fill_w2", opcode, 16'h1002); chk("fill_pc2", op_pc, 2);
    step(); chk("fill_w3", opcode, 16'h1003);
    // forward jump from op_pc 3
    rjmp = 12'h005; #1; chk("fwd_addr", pmem_addr, 9);
    step(); rjmp = 0; chk("fwd_nop", opcode, 0);
    step(); chk("fwd_w9", opcode, 16'h1009); chk("fwd_pc9", op_pc, 9);
    step(); chk("fwd_w10", opcode, 16'h100A);
    // back to 4, then self loop
    rjmp = 12'hFF9; step(); rjmp = 0;
    step(); chk("back_w4", opcode, 16'h1004);
    for (int i = 0; i < 3; i++) begin
      rjmp = 12'hFFF; #1; chk("loop_addr", pmem_addr, 4);
      step(); rjmp = 0; chk("loop_nop", opcode, 0);
      step(); chk("loop_w4", opcode, 16'h1004);
    end
    step(); chk("pre_hold_w5", opcode, 16'h1005); chk("pre_hold_cyc", opcode_cycle, 0);
    hold = 1; rjmp = 12'h010;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hold_en", pmem_en, 0);
      step(); chk("hold_w5", opcode, 16'h1005); chk("hold_pc", op_pc, 5); chk("hold_cyc", opcode_cycle, 1);
    end
    hold = 0; rjmp = 0;
    step(); chk("post_hold_w6", opcode, 16'h1006); chk("post_hold_cyc", opcode_cycle, 0);
    // wrap: jump to 0xFFE and run across the top
    rjmp = 12'hFF7; step(); rjmp = 0;
    step(); chk("wrap_pc_ffe", op_pc, 12'hFFE); chk("wrap_w_ffe", opcode, 16'h1FFE);
    step(); chk("wrap_pc_fff", op_pc, 12'hFFF);
    step(); chk("wrap_pc_000", op_pc, 12'h000); chk("wrap_w_000", opcode, 16'h1000);
    rjmp = 12'hFFE; step(); rjmp = 0;
    step(); chk("wrap_back_fff", op_pc, 12'hFFF);
    rjmp = 12'h001; #1; chk("wrap_jump_addr", pmem_addr, 12'h001);
    step(); rjmp = 0;
    step(); chk("wrap_jump_w1", opcode, 16'h1001); chk("wrap_jump_pc1", op_pc, 1);
    // reset during hold at op_pc 7
    rjmp = 12'h005; step(); rjmp = 0;
    step(); chk("pre_rst_pc7", op_pc, 7);
    hold = 1; step();
    rst = 0; step();
    chk("rst_hold_op", opcode, 0); chk("rst_hold_cyc", opcode_cycle, 0); chk("rst_hold_pc", op_pc, 0);
    rst = 1; hold = 0;
    step(); chk("refill_nop", opcode, 0);
    step(); chk("refill_w0", opcode, 16'h1000);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) != 0);
      hold = ($urandom_range(0, 3) == 0);
      rjmp = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'h000;
      step();
    end
    rst = 1; hold = 0; rjmp = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
